// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin arbiter sharing one single-port-per-direction RAM
// between the instruction-fetch master (requester 0) and the data master
// (requester 1). One transaction is granted per cycle; read data comes back
// exactly one cycle after the grant edge with a per-requester valid.
module ram_port_arbiter #(
  parameter int unsigned D_WIDTH = 16,
  parameter int unsigned A_WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,

  input  logic               req0,
  input  logic               we0,
  input  logic [A_WIDTH-1:0] addr0,
  input  logic [D_WIDTH-1:0] wdata0,
  output logic               gnt0,
  output logic               rvalid0,
  output logic [D_WIDTH-1:0] rdata0,

  input  logic               req1,
  input  logic               we1,
  input  logic [A_WIDTH-1:0] addr1,
  input  logic [D_WIDTH-1:0] wdata1,
  output logic               gnt1,
  output logic               rvalid1,
  output logic [D_WIDTH-1:0] rdata1,

  output logic [A_WIDTH-1:0] mem_address_write,
  output logic [D_WIDTH-1:0] mem_data_write,
  output logic               mem_write_enable,
  output logic [A_WIDTH-1:0] mem_address_read,
  input  logic [D_WIDTH-1:0] mem_data_read
);

  // Which requester owns the RAM read data presented this cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_R0   = 2'd1,
    OWN_R1   = 2'd2
  } rd_own_e;

  logic               rr_ptr_q, rr_ptr_d;
  rd_own_e            rd_own_q, rd_own_d;
  logic [D_WIDTH-1:0] hold0_q, hold0_d;
  logic [D_WIDTH-1:0] hold1_q, hold1_d;

  // Grant: a lone requester wins; on contention rr_ptr picks; nothing in reset.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      if (req0 && req1) begin
        gnt0 = ~rr_ptr_q;
        gnt1 = rr_ptr_q;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  // RAM drive follows the granted requester; requester 0 when idle to avoid X.
  always_comb begin
    mem_address_write = addr0;
    mem_data_write    = wdata0;
    mem_address_read  = addr0;
    if (gnt1) begin
      mem_address_write = addr1;
      mem_data_write    = wdata1;
      mem_address_read  = addr1;
    end
    mem_write_enable = (gnt0 && we0) || (gnt1 && we1);
  end

  // Next state: pointer moves to the loser, read ownership tracks a granted read,
  // hold registers capture the returned word so rdata stays put afterwards.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt0) begin
      rr_ptr_d = 1'b1;
    end else if (gnt1) begin
      rr_ptr_d = 1'b0;
    end

    rd_own_d = OWN_NONE;
    if (gnt0 && !we0) begin
      rd_own_d = OWN_R0;
    end else if (gnt1 && !we1) begin
      rd_own_d = OWN_R1;
    end

    hold0_d = hold0_q;
    hold1_d = hold1_q;
    if (rd_own_q == OWN_R0) begin
      hold0_d = mem_data_read;
    end
    if (rd_own_q == OWN_R1) begin
      hold1_d = mem_data_read;
    end
  end

  // State registers; async reset drops any pending read return.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= 1'b0;
      rd_own_q <= OWN_NONE;
      hold0_q  <= '0;
      hold1_q  <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      rd_own_q <= rd_own_d;
      hold0_q  <= hold0_d;
      hold1_q  <= hold1_d;
    end
  end

  // Read return: the RAM output register is presented directly while valid.
  always_comb begin
    rvalid0 = (rd_own_q == OWN_R0);
    rvalid1 = (rd_own_q == OWN_R1);
    rdata0  = rvalid0 ? mem_data_read : hold0_q;
    rdata1  = rvalid1 ? mem_data_read : hold1_q;
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: hand-derived vector table, reset/idle sequences,
// and random traffic against a transaction-level model of arbiter plus RAM.
module tb_ram_port_arbiter;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 4;
  localparam int unsigned DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] mem_address_write, mem_address_read;
  logic [DW-1:0] mem_data_write, mem_data_read;
  logic          mem_write_enable;

  ram_port_arbiter #(.D_WIDTH(DW), .A_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .mem_address_write(mem_address_write), .mem_data_write(mem_data_write),
    .mem_write_enable(mem_write_enable), .mem_address_read(mem_address_read),
    .mem_data_read(mem_data_read)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(input int i);
    return DW'(i * 17);
  endfunction

  // RAM with registered read; preloaded on the first edge, never cleared by reset.
  logic [DW-1:0] ram [DEPTH];
  logic          ram_loaded = 1'b0;
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < int'(DEPTH); i++) ram[i] <= init_val(i);
      ram_loaded <= 1'b1;
    end else if (mem_write_enable) begin
      ram[mem_address_write] <= mem_data_write;
    end
    mem_data_read <= ram[mem_address_read];
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: memory contents, who is favoured on contention, and the
  // read results the masters should currently be seeing.
  logic [DW-1:0] mm [DEPTH];
  logic          fav1;
  logic          m_rv0, m_rv1;
  logic [DW-1:0] m_rd0, m_rd1;

  task automatic model_reset();
    fav1  = 1'b0;
    m_rv0 = 1'b0;
    m_rv1 = 1'b0;
    m_rd0 = '0;
    m_rd1 = '0;
  endtask

  // Called at the negedge: compare against the model, commit the cycle, step.
  task automatic mcheck(input string tag, output logic g0, output logic g1);
    logic e0, e1;
    e0 = rst_n && req0 && (!req1 || !fav1);
    e1 = rst_n && req1 && (!req0 || fav1);
    chk($sformatf("%s_gnt0", tag), 32'(gnt0), 32'(e0));
    chk($sformatf("%s_gnt1", tag), 32'(gnt1), 32'(e1));
    chk($sformatf("%s_mwe", tag), 32'(mem_write_enable), 32'((e0 && we0) || (e1 && we1)));
    if (e0 || e1) begin
      if (e0 ? we0 : we1) begin
        chk($sformatf("%s_waddr", tag), 32'(mem_address_write), 32'(e0 ? addr0 : addr1));
        chk($sformatf("%s_wdata", tag), 32'(mem_data_write), 32'(e0 ? wdata0 : wdata1));
      end else begin
        chk($sformatf("%s_raddr", tag), 32'(mem_address_read), 32'(e0 ? addr0 : addr1));
      end
    end
    chk($sformatf("%s_rvalid0", tag), 32'(rvalid0), 32'(m_rv0));
    chk($sformatf("%s_rvalid1", tag), 32'(rvalid1), 32'(m_rv1));
    chk($sformatf("%s_rdata0", tag), 32'(rdata0), 32'(m_rd0));
    chk($sformatf("%s_rdata1", tag), 32'(rdata1), 32'(m_rd1));
    m_rv0 = e0 && !we0;
    m_rv1 = e1 && !we1;
    if (m_rv0) m_rd0 = mm[addr0];
    if (m_rv1) m_rd1 = mm[addr1];
    if (e0 && we0) mm[addr0] = wdata0;
    if (e1 && we1) mm[addr1] = wdata1;
    if (e0) fav1 = 1'b1;
    else if (e1) fav1 = 1'b0;
    g0 = e0;
    g1 = e1;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
  endtask

  typedef struct {
    logic          r0, w0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          r1, w1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic          g0, g1, mwe, rv0, rv1;
    logic [DW-1:0] q0, q1;
  } vec_t;

  vec_t tab[$];
  logic g0, g1;
  logic p0, p1;

  initial begin
    // r0 w0 a0 d0 | r1 w1 a1 d1 | gnt0 gnt1 mwe | rvalid0 rvalid1 rdata0 rdata1
    tab.push_back(vec_t'{1'b0,1'b0,4'd0,16'h0000, 1'b1,1'b1,4'd3,16'hBEEF, 1'b0,1'b1,1'b1, 1'b0,1'b0,16'h0000,16'h0000});
    tab.push_back(vec_t'{1'b1,1'b0,4'd3,16'h0000, 1'b0,1'b0,4'd0,16'h0000, 1'b1,1'b0,1'b0, 1'b0,1'b0,16'h0000,16'h0000});
    tab.push_back(vec_t'{1'b0,1'b0,4'd0,16'h0000, 1'b0,1'b0,4'd0,16'h0000, 1'b0,1'b0,1'b0, 1'b1,1'b0,16'hBEEF,16'h0000});
    tab.push_back(vec_t'{1'b0,1'b0,4'd0,16'h0000, 1'b1,1'b0,4'd2,16'h0000, 1'b0,1'b1,1'b0, 1'b0,1'b0,16'hBEEF,16'h0000});
    tab.push_back(vec_t'{1'b1,1'b0,4'd1,16'h0000, 1'b1,1'b0,4'd2,16'h0000, 1'b1,1'b0,1'b0, 1'b0,1'b1,16'hBEEF,16'h0022});
    tab.push_back(vec_t'{1'b1,1'b0,4'd1,16'h0000, 1'b1,1'b0,4'd2,16'h0000, 1'b0,1'b1,1'b0, 1'b1,1'b0,16'h0011,16'h0022});
    tab.push_back(vec_t'{1'b1,1'b0,4'd1,16'h0000, 1'b1,1'b0,4'd2,16'h0000, 1'b1,1'b0,1'b0, 1'b0,1'b1,16'h0011,16'h0022});
    tab.push_back(vec_t'{1'b1,1'b0,4'd1,16'h0000, 1'b1,1'b0,4'd2,16'h0000, 1'b0,1'b1,1'b0, 1'b1,1'b0,16'h0011,16'h0022});
    tab.push_back(vec_t'{1'b0,1'b0,4'd0,16'h0000, 1'b0,1'b0,4'd0,16'h0000, 1'b0,1'b0,1'b0, 1'b0,1'b1,16'h0011,16'h0022});
    tab.push_back(vec_t'{1'b1,1'b0,4'd1,16'h0000, 1'b0,1'b0,4'd0,16'h0000, 1'b1,1'b0,1'b0, 1'b0,1'b0,16'h0011,16'h0022});
    tab.push_back(vec_t'{1'b1,1'b0,4'd1,16'h0000, 1'b1,1'b0,4'd4,16'h0000, 1'b0,1'b1,1'b0, 1'b1,1'b0,16'h0011,16'h0022});
    tab.push_back(vec_t'{1'b1,1'b0,4'd1,16'h0000, 1'b1,1'b0,4'd6,16'h0000, 1'b1,1'b0,1'b0, 1'b0,1'b1,16'h0011,16'h0044});
    tab.push_back(vec_t'{1'b1,1'b0,4'd1,16'h0000, 1'b1,1'b0,4'd6,16'h0000, 1'b0,1'b1,1'b0, 1'b1,1'b0,16'h0011,16'h0044});
    tab.push_back(vec_t'{1'b0,1'b0,4'd0,16'h0000, 1'b1,1'b1,4'd5,16'h1234, 1'b0,1'b1,1'b1, 1'b0,1'b1,16'h0011,16'h0066});
    tab.push_back(vec_t'{1'b0,1'b0,4'd0,16'h0000, 1'b1,1'b0,4'd5,16'h0000, 1'b0,1'b1,1'b0, 1'b0,1'b0,16'h0011,16'h0066});
    tab.push_back(vec_t'{1'b0,1'b0,4'd0,16'h0000, 1'b0,1'b0,4'd0,16'h0000, 1'b0,1'b0,1'b0, 1'b0,1'b1,16'h0011,16'h1234});
    tab.push_back(vec_t'{1'b1,1'b1,4'd7,16'hA5A5, 1'b1,1'b1,4'd8,16'h5A5A, 1'b1,1'b0,1'b1, 1'b0,1'b0,16'h0011,16'h1234});
    tab.push_back(vec_t'{1'b1,1'b0,4'd7,16'h0000, 1'b1,1'b1,4'd8,16'h5A5A, 1'b0,1'b1,1'b1, 1'b0,1'b0,16'h0011,16'h1234});
    tab.push_back(vec_t'{1'b1,1'b0,4'd7,16'h0000, 1'b0,1'b0,4'd0,16'h0000, 1'b1,1'b0,1'b0, 1'b0,1'b0,16'h0011,16'h1234});
    tab.push_back(vec_t'{1'b1,1'b0,4'd8,16'h0000, 1'b0,1'b0,4'd0,16'h0000, 1'b1,1'b0,1'b0, 1'b1,1'b0,16'hA5A5,16'h1234});
    tab.push_back(vec_t'{1'b0,1'b0,4'd0,16'h0000, 1'b0,1'b0,4'd0,16'h0000, 1'b0,1'b0,1'b0, 1'b1,1'b0,16'h5A5A,16'h1234});

    for (int i = 0; i < int'(DEPTH); i++) mm[i] = init_val(i);
    model_reset();

    // Reset: requests present but nothing may be granted or written.
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 4'd2, 16'hFFFF, 1'b1, 1'b1, 4'd3, 16'hEEEE);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt0", 32'(gnt0), 32'(0));
    chk("rst_gnt1", 32'(gnt1), 32'(0));
    chk("rst_mwe", 32'(mem_write_enable), 32'(0));
    chk("rst_rvalid0", 32'(rvalid0), 32'(0));
    chk("rst_rvalid1", 32'(rvalid1), 32'(0));
    chk("rst_rdata0", 32'(rdata0), 32'(0));
    chk("rst_rdata1", 32'(rdata1), 32'(0));
    drive(1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 4'd0, 16'h0000);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed vector table.
    foreach (tab[i]) begin
      drive(tab[i].r0, tab[i].w0, tab[i].a0, tab[i].d0, tab[i].r1, tab[i].w1, tab[i].a1, tab[i].d1);
      @(negedge clk);
      chk($sformatf("tab%0d_gnt0", i), 32'(gnt0), 32'(tab[i].g0));
      chk($sformatf("tab%0d_gnt1", i), 32'(gnt1), 32'(tab[i].g1));
      chk($sformatf("tab%0d_mwe", i), 32'(mem_write_enable), 32'(tab[i].mwe));
      chk($sformatf("tab%0d_rvalid0", i), 32'(rvalid0), 32'(tab[i].rv0));
      chk($sformatf("tab%0d_rvalid1", i), 32'(rvalid1), 32'(tab[i].rv1));
      chk($sformatf("tab%0d_rdata0", i), 32'(rdata0), 32'(tab[i].q0));
      chk($sformatf("tab%0d_rdata1", i), 32'(rdata1), 32'(tab[i].q1));
      mcheck($sformatf("tabm%0d", i), g0, g1);
    end

    // Reset pulse across the grant edge of a pending read and a pending write.
    drive(1'b1, 1'b0, 4'd1, 16'h0000, 1'b1, 1'b1, 4'd9, 16'h7777);
    @(negedge clk);
    chk("mid_gnt0_pre", 32'(gnt0), 32'(!fav1));
    chk("mid_gnt1_pre", 32'(gnt1), 32'(fav1));
    #1 rst_n = 1'b0;
    #1;
    chk("mid_gnt0", 32'(gnt0), 32'(0));
    chk("mid_gnt1", 32'(gnt1), 32'(0));
    chk("mid_mwe", 32'(mem_write_enable), 32'(0));
    chk("mid_rdata0", 32'(rdata0), 32'(0));
    chk("mid_rdata1", 32'(rdata1), 32'(0));
    @(posedge clk);
    #1;
    chk("mid_rvalid0", 32'(rvalid0), 32'(0));
    chk("mid_rvalid1", 32'(rvalid1), 32'(0));
    chk("mid_mwe_post", 32'(mem_write_enable), 32'(0));
    drive(1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 4'd0, 16'h0000);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    drive(1'b0, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 4'd9, 16'h0000);
    @(negedge clk);
    mcheck("rel_r1", g0, g1);
    drive(1'b1, 1'b0, 4'd1, 16'h0000, 1'b0, 1'b0, 4'd0, 16'h0000);
    @(negedge clk);
    chk("rel_addr9_kept", 32'(rdata1), 32'(16'h0099));
    mcheck("rel_r0", g0, g1);

    // Idle: everything quiet, read data holds.
    drive(1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 4'd0, 16'h0000);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      mcheck($sformatf("idle%0d", i), g0, g1);
    end

    // Random traffic: each master holds its request until granted.
    p0 = 1'b0;
    p1 = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!p0 && $urandom_range(0, 3) != 0) begin
        p0 = 1'b1;
        we0 = 1'($urandom_range(0, 1));
        addr0 = AW'($urandom_range(0, 15));
        wdata0 = DW'($urandom);
      end
      if (!p1 && $urandom_range(0, 2) != 0) begin
        p1 = 1'b1;
        we1 = 1'($urandom_range(0, 1));
        addr1 = AW'($urandom_range(0, 15));
        wdata1 = DW'($urandom);
      end
      req0 = p0;
      req1 = p1;
      @(negedge clk);
      mcheck($sformatf("rnd%0d", i), g0, g1);
      if (g0) p0 = 1'b0;
      if (g1) p1 = 1'b0;
    end
    drive(1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 4'd0, 16'h0000);
    @(negedge clk);
    mcheck("tail", g0, g1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
